// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: divides clk into a seconds tick, runs the BCD
// seconds/minutes/hours carry chain and offers a key-driven set mode.
`timescale 1ns/1ps
module clock_time_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [7:0] hour,
   output logic [1:0] mode,
   output logic       tick,
   output logic       day_co
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } stateType;

   stateType      r_state;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_sec;
   logic [7:0]    r_min;
   logic [7:0]    r_hour;
   logic          r_tick;
   logic          r_dayCo;
   logic          r_keyModePrev;
   logic          r_keyIncPrev;

   logic          w_modeEdge;
   logic          w_incEdge;
   logic          w_tick;
   logic          w_secWrap;
   logic          w_minWrap;
   logic          w_hourWrap;
   logic [7:0]    w_secNext;
   logic [7:0]    w_minNext;
   logic [7:0]    w_hourNext;

   // Modulo-60 BCD increment; every result stays legal BCD in 00..59.
   function automatic logic [7:0] bcdInc60(input logic [7:0] v);
      logic [7:0] res;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) begin
            res = 8'h00;
         end else begin
            res = {v[7:4] + 4'd1, 4'd0};
         end
      end else begin
         res = {v[7:4], v[3:0] + 4'd1};
      end
      return res;
   endfunction

   function automatic logic [7:0] bcdInc24(input logic [7:0] v);
      logic [7:0] res;
      if (v == 8'h23) begin
         res = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         res = {v[7:4] + 4'd1, 4'd0};
      end else begin
         res = {v[7:4], v[3:0] + 4'd1};
      end
      return res;
   endfunction

   // A mode edge in the same cycle as an increment edge swallows the increment.
   assign w_modeEdge = key_mode & ~r_keyModePrev;
   assign w_incEdge  = key_inc & ~r_keyIncPrev & ~w_modeEdge;
   assign w_tick     = (r_state == RUN) && en && (r_presc == PRESC_LAST);

   assign w_secWrap  = (r_sec  == 8'h59);
   assign w_minWrap  = (r_min  == 8'h59);
   assign w_hourWrap = (r_hour == 8'h23);
   assign w_secNext  = bcdInc60(r_sec);
   assign w_minNext  = bcdInc60(r_min);
   assign w_hourNext = bcdInc24(r_hour);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= RUN;
         r_presc       <= '0;
         r_sec         <= 8'h00;
         r_min         <= 8'h00;
         r_hour        <= 8'h00;
         r_tick        <= 1'b0;
         r_dayCo       <= 1'b0;
         r_keyModePrev <= 1'b0;
         r_keyIncPrev  <= 1'b0;
      end else begin
         r_keyModePrev <= key_mode;
         r_keyIncPrev  <= key_inc;
         r_tick        <= w_tick;
         r_dayCo       <= w_tick & w_secWrap & w_minWrap & w_hourWrap;

         unique case (r_state)
            RUN: begin
               if (en) begin
                  r_presc <= w_tick ? '0 : r_presc + PW'(1);
               end
               if (w_tick) begin
                  r_sec <= w_secNext;
                  if (w_secWrap) begin
                     r_min <= w_minNext;
                     if (w_minWrap) begin
                        r_hour <= w_hourNext;
                     end
                  end
               end
               // A tick landing on the mode edge is still counted before leaving RUN.
               if (w_modeEdge) begin
                  r_state <= SET_HR;
                  r_presc <= '0;
               end
            end
            SET_HR: begin
               r_presc <= '0;
               if (w_modeEdge) begin
                  r_state <= SET_MIN;
               end else if (w_incEdge) begin
                  r_hour <= w_hourNext;
               end
            end
            SET_MIN: begin
               r_presc <= '0;
               if (w_modeEdge) begin
                  r_state <= RUN;
                  r_sec   <= 8'h00;
               end else if (w_incEdge) begin
                  r_min <= w_minNext;
               end
            end
            default: begin
               r_state <= RUN;
               r_presc <= '0;
            end
         endcase
      end
   end

   assign sec    = r_sec;
   assign min    = r_min;
   assign hour   = r_hour;
   assign mode   = r_state;
   assign tick   = r_tick;
   assign day_co = r_dayCo;

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Time-of-day controller for the BCD counter datapath (mod-60 seconds/minutes, mod-24 hours).
- Divides clk into a seconds tick and sequences the seconds→minutes→hours carry chain.
- Provides a key-driven set mode for hours and minutes.
- Sits between the debounced key inputs and the display driver; outputs packed BCD time.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (≥1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  run enable; low freezes timekeeping (RUN state only)
key_mode  input  1  debounced mode key, level, synchronous to clk
key_inc  input  1  debounced increment key, level, synchronous to clk
sec  output  8  BCD seconds {tens[7:4],units[3:0]}, 00..59
min  output  8  BCD minutes, 00..59
hour  output  8  BCD hours, 00..23
mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN (3 never driven)
tick  output  1  one-cycle pulse when a second is counted
day_co  output  1  one-cycle pulse on 23:59:59→00:00:00 wrap

Behaviour:
- Reset (rst low, asynchronous):
  - sec=min=hour=8'h00, mode=RUN, tick=0, day_co=0.
  - Prescaler=0; key edge registers=0.
  - Takes effect immediately, including mid-set or mid-carry.
- Key edges:
  - Registered previous value; edge = key & ~key_prev.
  - The action happens on the same rising edge where the edge is first seen; the result is visible the next cycle.
  - A held key acts once.
- Prescaler: 0..TICK_DIV-1 counter, counting in RUN only while en=1.
  - At TICK_DIV-1 with en=1: wraps to 0 and generates an internal tick.
  - The tick output is registered: high for exactly the cycle after the seconds update.
  - en=0: prescaler and time hold.
  - TICK_DIV=1: tick every enabled cycle.
- Carry chain on a tick:
  - seconds units 9→0 carries to tens; sec 59→00 carries to min.
  - min 59→00 carries to hour.
  - hour 23→00 with min and sec also wrapping asserts day_co (registered, aligned with tick).
  - Illegal BCD never produced.
- FSM on a key_mode edge: RUN→SET_HR→SET_MIN→RUN.
  - Entering SET_HR: prescaler cleared and held at 0; no ticks in SET states.
  - SET_HR, key_inc edge: hour+1, 23→00, no carry out, day_co stays 0.
  - SET_MIN, key_inc edge: min+1, 59→00, no carry to hour.
  - SET_MIN→RUN: sec cleared to 00 and prescaler restarts from 0, so the first tick arrives TICK_DIV enabled cycles later.
  - sec is held (not cleared) in SET_HR/SET_MIN until exit.
- Simultaneous events:
  - key_mode and key_inc edges in the same cycle: mode transition wins, inc ignored.
  - Tick and key_mode edge in the same RUN cycle: tick applied (including carries), and mode becomes SET_HR on that edge.
  - key_inc in RUN: ignored.
  - en has no effect in SET states; increments work with en=0.

Test Plan:
- TICK_DIV=4, en=1, release rst → tick every 4th cycle; after 4 ticks sec=8'h04, mode=0.
- Preload 23:59:58 via set mode plus ticks, run 2 ticks → 23:59:59 then 00:00:00; day_co high only with the second tick.
- key_mode edge; key_inc ×25 in SET_HR from hour=8'h22 → hour sequence ends at 8'h23 then wraps 8'h00… final 8'h23; min/sec unchanged; no tick, day_co=0.
- SET_MIN with min=8'h59, one key_inc → min=8'h00, hour unchanged; key_mode → mode=0, sec=8'h00, first tick exactly 4 cycles later.
- key_mode and key_inc rise in the same cycle in SET_HR → mode=2, hour unchanged; key_inc held high 10 cycles → single increment.
- en=0 for 20 cycles in RUN → no ticks, time frozen; assert rst mid-SET_MIN → all outputs 0, mode=0 immediately.
